// File: rtl/alu_msub_pkg.sv
// Shared definitions for the multi-byte subtract sequencer: FSM encodings and
// the 8085 flag layout used by the ALU flag register.
package alu_msub_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   // Bit positions inside the 8085 PSW flag byte
   localparam int FLAG_S  = 7;
   localparam int FLAG_Z  = 6;
   localparam int FLAG_AC = 4;
   localparam int FLAG_P  = 2;
   localparam int FLAG_CY = 0;

   typedef struct packed {
      logic s;
      logic z;
      logic ac;
      logic p;
      logic cy;
   } flags_t;

   function automatic logic [7:0] flags_to_psw(input flags_t f);
      logic [7:0] psw;
      psw          = 8'h02;
      psw[FLAG_S]  = f.s;
      psw[FLAG_Z]  = f.z;
      psw[FLAG_AC] = f.ac;
      psw[FLAG_P]  = f.p;
      psw[FLAG_CY] = f.cy;
      return psw;
   endfunction

endpackage

// File: rtl/alu_msub_sub8b.sv
// Ripple-borrow subtractor: oD = iJ - iK - borrow, exposing the borrow out of
// every bit so callers can pick off carry (MSB) and half-carry (bit 3).
module sub8b #(
   parameter int DATASIZE = 8,
   parameter bit USE_EXTB = 1'b0
) (
   input  logic [DATASIZE-1:0] iJ,
   input  logic [DATASIZE-1:0] iK,
   input  logic [DATASIZE-1:0] iB,
   output logic [DATASIZE-1:0] oD,
   output logic [DATASIZE-1:0] oB
);

   genvar g;
   generate
      for (g = 0; g < DATASIZE; g++) begin : g_bit
         logic b_in;
         logic b_out;
         // With USE_EXTB each bit takes its own external borrow; otherwise only
         // iB[0] enters and the rest ripples from the bit below.
         if (g == 0 || USE_EXTB) begin : g_ext
            assign b_in = iB[g];
         end else begin : g_rip
            assign b_in = g_bit[g-1].b_out;
         end
         assign b_out = (~iJ[g] & iK[g]) | (~(iJ[g] ^ iK[g]) & b_in);
         assign oD[g] = iJ[g] ^ iK[g] ^ b_in;
         assign oB[g] = b_out;
      end

      if (!USE_EXTB && DATASIZE > 1) begin : g_tie
         logic unused_ext;
         assign unused_ext = ^iB[DATASIZE-1:1];
      end
   endgenerate

endmodule

// File: rtl/alu_msub.sv
// Multi-byte subtract sequencer: one byte pair per beat through sub8b, borrow
// chained across beats, registered result bytes and final 8085-style flags.
module alu_msub
   import alu_msub_pkg::*;
#(
   parameter int DATASIZE = 8,
   parameter int CNTSIZE  = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                iStart,
   input  logic [CNTSIZE-1:0]  iLen,
   input  logic                iBin,
   input  logic [DATASIZE-1:0] iJ,
   input  logic [DATASIZE-1:0] iK,
   input  logic                iValid,
   output logic                oReady,
   output logic [DATASIZE-1:0] oD,
   output logic                oDValid,
   input  logic                iDReady,
   output logic                oBusy,
   output logic                oDone,
   output logic                oCY,
   output logic                oZ,
   output logic                oS,
   output logic                oP,
   output logic                oAC
);

   logic [1:0]          state_q,  state_d;
   logic [CNTSIZE-1:0]  cnt_q,    cnt_d;
   logic [CNTSIZE-1:0]  len_q,    len_d;
   logic                borrow_q, borrow_d;
   logic                zacc_q,   zacc_d;
   logic [DATASIZE-1:0] od_q,     od_d;
   logic                dvalid_q, dvalid_d;
   logic                done_q,   done_d;
   flags_t              flags_q,  flags_d;

   logic [DATASIZE-1:0] sub_d;
   logic [DATASIZE-1:0] sub_b;
   logic                ready;
   logic                beat;
   logic                diff_zero;

   sub8b #(
      .DATASIZE (DATASIZE),
      .USE_EXTB (1'b0)
   ) u_sub (
      .iJ (iJ),
      .iK (iK),
      .iB ({{(DATASIZE-1){1'b0}}, borrow_q}),
      .oD (sub_d),
      .oB (sub_b)
   );

   assign ready     = (state_q == ST_RUN) && (!dvalid_q || iDReady);
   assign beat      = ready && iValid;
   assign diff_zero = (sub_d == '0);

   // A start arriving while oDone is still high is dropped so the pulse cycle
   // can never open a new operation.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      len_d    = len_q;
      borrow_d = borrow_q;
      zacc_d   = zacc_q;
      od_d     = od_q;
      dvalid_d = dvalid_q;
      done_d   = 1'b0;
      flags_d  = flags_q;

      case (state_q)
         ST_IDLE: begin
            if (iStart && !done_q) begin
               state_d  = ST_RUN;
               len_d    = iLen;
               borrow_d = iBin;
               cnt_d    = '0;
               zacc_d   = 1'b1;
               flags_d  = '0;
            end
         end

         ST_RUN: begin
            if (dvalid_q && iDReady) begin
               dvalid_d = 1'b0;
            end
            if (beat) begin
               od_d     = sub_d;
               dvalid_d = 1'b1;
               borrow_d = sub_b[DATASIZE-1];
               zacc_d   = zacc_q & diff_zero;
               if (cnt_q == len_q) begin
                  flags_d.cy = sub_b[DATASIZE-1];
                  flags_d.s  = sub_d[DATASIZE-1];
                  flags_d.p  = ~^sub_d;
                  flags_d.ac = sub_b[3];
                  flags_d.z  = zacc_q & diff_zero;
                  state_d    = ST_DRAIN;
               end else begin
                  cnt_d = cnt_q + CNTSIZE'(1);
               end
            end
         end

         ST_DRAIN: begin
            if (dvalid_q && iDReady) begin
               dvalid_d = 1'b0;
               done_d   = 1'b1;
               state_d  = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         len_q    <= '0;
         borrow_q <= 1'b0;
         zacc_q   <= 1'b0;
         od_q     <= '0;
         dvalid_q <= 1'b0;
         done_q   <= 1'b0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         len_q    <= len_d;
         borrow_q <= borrow_d;
         zacc_q   <= zacc_d;
         od_q     <= od_d;
         dvalid_q <= dvalid_d;
         done_q   <= done_d;
         flags_q  <= flags_d;
      end
   end

   assign oReady  = ready;
   assign oD      = od_q;
   assign oDValid = dvalid_q;
   assign oBusy   = (state_q != ST_IDLE);
   assign oDone   = done_q;
   assign oCY     = flags_q.cy;
   assign oZ      = flags_q.z;
   assign oS      = flags_q.s;
   assign oP      = flags_q.p;
   assign oAC     = flags_q.ac;

endmodule

// File: tb/tb_alu_msub.sv
// Self-checking bench for alu_msub: scoreboard of result bytes plus flag,
// handshake, reset and start-abuse scenarios.
module tb_alu_msub;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       iStart;
   logic [1:0] iLen;
   logic       iBin;
   logic [7:0] iJ;
   logic [7:0] iK;
   logic       iValid;
   logic       oReady;
   logic [7:0] oD;
   logic       oDValid;
   logic       iDReady;
   logic       oBusy;
   logic       oDone;
   logic       oCY, oZ, oS, oP, oAC;

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0] sb_q[$];

   alu_msub #(.DATASIZE(8), .CNTSIZE(2)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .iStart  (iStart),
      .iLen    (iLen),
      .iBin    (iBin),
      .iJ      (iJ),
      .iK      (iK),
      .iValid  (iValid),
      .oReady  (oReady),
      .oD      (oD),
      .oDValid (oDValid),
      .iDReady (iDReady),
      .oBusy   (oBusy),
      .oDone   (oDone),
      .oCY     (oCY),
      .oZ      (oZ),
      .oS      (oS),
      .oP      (oP),
      .oAC     (oAC)
   );

   always #5 clk = ~clk;

   // Full-width reference difference; bits above the operand hold the borrow.
   function automatic logic [39:0] model_diff(input int len, input logic bin,
                                              input logic [31:0] j, input logic [31:0] k);
      logic [39:0] jm;
      logic [39:0] km;
      jm = '0;
      km = '0;
      for (int b = 0; b < 32; b++) begin
         if (b < (len + 1) * 8) begin
            jm[b] = j[b];
            km[b] = k[b];
         end
      end
      return jm - km - {39'b0, bin};
   endfunction

   // Drives one operation; returns at the falling edge of the oDone cycle.
   task automatic run_op(input int len, input logic bin, input logic [31:0] j,
                         input logic [31:0] k, input int stall_at, input int stall_cnt,
                         input bit abuse);
      logic [39:0] d;
      logic [7:0]  exp_b;
      logic [7:0]  held;
      bit          hold_v;
      bit          seen_done;
      int          sent, got, cyc, idx, acc_cyc, first_valid;
      d = model_diff(len, bin, j, k);
      sent = 0; got = 0; cyc = 0; hold_v = 1'b0; held = '0; seen_done = 1'b0;
      acc_cyc = -1; first_valid = -1;
      sb_q.delete();
      @(posedge clk); #1;
      iStart = 1'b1; iLen = 2'(len); iBin = bin; iValid = 1'b0; iDReady = 1'b1;
      @(posedge clk); #1;
      iStart = 1'b0;
      while (cyc < 200) begin
         idx     = (sent > 3) ? 3 : sent;
         iValid  = (sent <= len);
         iJ      = j[idx*8 +: 8];
         iK      = k[idx*8 +: 8];
         iDReady = !(cyc >= stall_at && cyc < stall_at + stall_cnt);
         if (abuse && cyc == 1) begin
            iStart = 1'b1;
            iLen   = 2'd3;
         end else begin
            iStart = 1'b0;
         end
         @(negedge clk);
         if (oDone) begin
            seen_done = 1'b1;
            break;
         end
         if (oDValid && first_valid < 0) first_valid = cyc;
         if (hold_v) begin
            vectors++;
            if (oD !== held) begin
               miscompares++;
               $display("[TB] FAIL stall_hold: oD=%02h required %02h", oD, held);
            end
         end
         if (oDValid && !iDReady) begin
            vectors++;
            if (oReady !== 1'b0) begin
               miscompares++;
               $display("[TB] FAIL stall_ready: oReady=%0b required 0", oReady);
            end
            hold_v = 1'b1;
            held   = oD;
         end else begin
            hold_v = 1'b0;
         end
         if (oDValid && iDReady) begin
            vectors++;
            if (sb_q.size() == 0) begin
               miscompares++;
               $display("[TB] FAIL sb_extra: oD=%02h required no byte", oD);
            end else begin
               exp_b = sb_q.pop_front();
               if (oD !== exp_b) begin
                  miscompares++;
                  $display("[TB] FAIL sb_byte%0d: oD=%02h required %02h", got, oD, exp_b);
               end
            end
            got++;
         end
         if (iValid && oReady) begin
            sb_q.push_back(d[sent*8 +: 8]);
            if (acc_cyc < 0) acc_cyc = cyc;
            sent++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      iStart = 1'b0;
      iValid = 1'b0;
      iDReady = 1'b1;
      vectors++;
      if (!seen_done) begin
         miscompares++;
         $display("[TB] FAIL done_timeout: oDone=0 after %0d cycles required 1", cyc);
      end
      vectors++;
      if (got != len + 1 || sb_q.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL byte_count: got=%0d pending=%0d required %0d/0", got, sb_q.size(), len + 1);
      end
      vectors++;
      if (first_valid != acc_cyc + 1) begin
         miscompares++;
         $display("[TB] FAIL latency: first oDValid cycle %0d required %0d", first_valid, acc_cyc + 1);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; iStart = 1'b0; iLen = '0; iBin = 1'b0; iJ = '0; iK = '0;
      iValid = 1'b0; iDReady = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({oD, oDValid, oReady, oBusy, oDone, oS, oZ, oAC, oP, oCY} !== 17'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs: got %05h required 00000",
                  {oD, oDValid, oReady, oBusy, oDone, oS, oZ, oAC, oP, oCY});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_flags(input string name, input int len, input logic bin,
                             input logic [31:0] j, input logic [31:0] k,
                             input int stall_at, input int stall_cnt, input logic [4:0] exp_f);
      run_op(len, bin, j, k, stall_at, stall_cnt, 1'b0);
      vectors++;
      if ({oS, oZ, oAC, oP, oCY} !== exp_f) begin
         miscompares++;
         $display("[TB] FAIL %s flags SZAPC: got %05b required %05b", name, {oS, oZ, oAC, oP, oCY}, exp_f);
      end
      @(negedge clk);
      vectors++;
      if (oDone !== 1'b0 || oBusy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL %s done_pulse: oDone=%0b oBusy=%0b required 0/0", name, oDone, oBusy);
      end
   endtask

   task automatic test_start_abuse();
      run_op(1, 1'b0, 32'h0000_0302, 32'h0000_0101, 100, 0, 1'b1);
      vectors++;
      if ({oS, oZ, oAC, oP, oCY} !== 5'b00000) begin
         miscompares++;
         $display("[TB] FAIL start_abuse flags: got %05b required 00000", {oS, oZ, oAC, oP, oCY});
      end
   endtask

   task automatic test_reset_mid();
      @(posedge clk); #1;
      iStart = 1'b1; iLen = 2'd3; iBin = 1'b0;
      @(posedge clk); #1;
      iStart = 1'b0; iValid = 1'b1; iJ = 8'h44; iK = 8'h11;
      @(posedge clk); #1;
      iValid = 1'b0;
      vectors++;
      if (oDValid !== 1'b1 || oD !== 8'h33) begin
         miscompares++;
         $display("[TB] FAIL mid_byte1: oDValid=%0b oD=%02h required 1/33", oDValid, oD);
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if ({oD, oDValid, oReady, oBusy, oDone, oS, oZ, oAC, oP, oCY} !== 17'd0) begin
         miscompares++;
         $display("[TB] FAIL mid_reset: got %05h required 00000",
                  {oD, oDValid, oReady, oBusy, oDone, oS, oZ, oAC, oP, oCY});
      end
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         vectors++;
         if (oDone !== 1'b0 || oBusy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mid_after%0d: oDone=%0b oBusy=%0b required 0/0", i, oDone, oBusy);
         end
      end
   endtask

   task automatic test_back_to_back();
      run_op(0, 1'b0, 32'h00, 32'h01, 100, 0, 1'b0);
      iStart = 1'b1; iLen = 2'd0; iBin = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if (oBusy !== 1'b0 || {oS, oZ, oAC, oP, oCY} !== 5'b10111) begin
         miscompares++;
         $display("[TB] FAIL b2b_ignored: oBusy=%0b flags=%05b required 0/10111", oBusy, {oS, oZ, oAC, oP, oCY});
      end
      @(posedge clk); #1;
      iStart = 1'b0;
      vectors++;
      if (oBusy !== 1'b1 || {oS, oZ, oAC, oP, oCY} !== 5'b00000) begin
         miscompares++;
         $display("[TB] FAIL b2b_start: oBusy=%0b flags=%05b required 1/00000", oBusy, {oS, oZ, oAC, oP, oCY});
      end
      iValid = 1'b1; iJ = 8'h07; iK = 8'h02; iDReady = 1'b1;
      @(negedge clk);
      vectors++;
      if (oReady !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL b2b_ready: oReady=%0b required 1", oReady);
      end
      @(posedge clk); #1;
      iValid = 1'b0;
      @(negedge clk);
      vectors++;
      if (oDValid !== 1'b1 || oD !== 8'h05) begin
         miscompares++;
         $display("[TB] FAIL b2b_result: oDValid=%0b oD=%02h required 1/05", oDValid, oD);
      end
      @(negedge clk);
      vectors++;
      if (oDone !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL b2b_done: oDone=%0b required 1", oDone);
      end
   endtask

   initial begin
      test_reset();
      test_flags("one_byte",   0, 1'b0, 32'h05, 32'h03, 100, 0, 5'b00000);
      test_flags("borrow_chn", 1, 1'b0, 32'h0100, 32'h0001, 100, 0, 5'b00010);
      test_flags("underflow",  0, 1'b0, 32'h00, 32'h01, 100, 0, 5'b10111);
      test_flags("zero_bin",   0, 1'b1, 32'h10, 32'h0F, 100, 0, 5'b01110);
      test_flags("backpress",  3, 1'b0, 32'h1234_5678, 32'h8765_4321, 2, 5, 5'b10101);
      test_flags("full_zero",  3, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 100, 0, 5'b01010);
      test_flags("low_nz",     3, 1'b0, 32'h0000_0005, 32'h0000_0003, 100, 0, 5'b00010);
      test_start_abuse();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

endmodule
